// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: result-source handshakes, register-file write port, retirement
// and forwarding signals shared between the write-back arbiter and its neighbours.
// Widths come from REG_ADDR_WIDTH / REG_DATA_WIDTH / COMMIT_ID_WIDTH macros.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif

interface wb_arbiter_if #(
  parameter int unsigned RETIRE_CNT_W = 32
);
  localparam int unsigned AW = `REG_ADDR_WIDTH;
  localparam int unsigned DW = `REG_DATA_WIDTH;
  localparam int unsigned IW = `COMMIT_ID_WIDTH;

  logic                    alu_we_i;
  logic [AW-1:0]           alu_waddr_i;
  logic [DW-1:0]           alu_wdata_i;
  logic [IW-1:0]           alu_commit_id_i;
  logic                    alu_ready_o;

  logic                    mdu_we_i;
  logic [AW-1:0]           mdu_waddr_i;
  logic [DW-1:0]           mdu_wdata_i;
  logic [IW-1:0]           mdu_commit_id_i;
  logic                    mdu_ready_o;

  logic                    lsu_we_i;
  logic [AW-1:0]           lsu_waddr_i;
  logic [DW-1:0]           lsu_wdata_i;
  logic [IW-1:0]           lsu_commit_id_i;
  logic                    lsu_ready_o;

  logic                    rf_we_o;
  logic [AW-1:0]           rf_waddr_o;
  logic [DW-1:0]           rf_wdata_o;
  logic                    commit_valid_o;
  logic [IW-1:0]           commit_id_o;
  logic                    fwd_valid_o;
  logic [AW-1:0]           fwd_waddr_o;
  logic [DW-1:0]           fwd_wdata_o;
  logic [RETIRE_CNT_W-1:0] retire_cnt_o;

  // Arbiter side.
  modport slave (
    input  alu_we_i, alu_waddr_i, alu_wdata_i, alu_commit_id_i,
    input  mdu_we_i, mdu_waddr_i, mdu_wdata_i, mdu_commit_id_i,
    input  lsu_we_i, lsu_waddr_i, lsu_wdata_i, lsu_commit_id_i,
    output alu_ready_o, mdu_ready_o, lsu_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o,
    output commit_valid_o, commit_id_o,
    output fwd_valid_o, fwd_waddr_o, fwd_wdata_o,
    output retire_cnt_o
  );

  // Pipeline / register-file side.
  modport master (
    output alu_we_i, alu_waddr_i, alu_wdata_i, alu_commit_id_i,
    output mdu_we_i, mdu_waddr_i, mdu_wdata_i, mdu_commit_id_i,
    output lsu_we_i, lsu_waddr_i, lsu_wdata_i, lsu_commit_id_i,
    input  alu_ready_o, mdu_ready_o, lsu_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o,
    input  commit_valid_o, commit_id_o,
    input  fwd_valid_o, fwd_waddr_o, fwd_wdata_o,
    input  retire_cnt_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin write-back arbiter for ALU/MDU/LSU results feeding a
// one-entry registered output stage (register-file write + retirement).
// Optional feature macro: WB_FWD_EN enables the operand-bypass outputs fwd_*.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif

module wb_arbiter #(
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  wb_arbiter_if.slave  bus
);
  localparam int unsigned AW   = `REG_ADDR_WIDTH;
  localparam int unsigned DW   = `REG_DATA_WIDTH;
  localparam int unsigned IW   = `COMMIT_ID_WIDTH;
  localparam int unsigned NSRC = 3;

  typedef enum logic [1:0] {
    PRI_ALU = 2'd0,
    PRI_MDU = 2'd1,
    PRI_LSU = 2'd2
  } pri_e;

  pri_e                    pri_q;
  pri_e                    pri_d;
  logic [NSRC-1:0]         req_c;
  logic [NSRC-1:0]         grant_c;
  logic                    accept_c;
  logic [AW-1:0]           sel_waddr_c;
  logic [DW-1:0]           sel_wdata_c;
  logic [IW-1:0]           sel_id_c;

  logic                    rf_we_q;
  logic [AW-1:0]           rf_waddr_q;
  logic [DW-1:0]           rf_wdata_q;
  logic                    commit_valid_q;
  logic [IW-1:0]           commit_id_q;
  logic [RETIRE_CNT_W-1:0] retire_cnt_q;

  assign req_c = {bus.lsu_we_i, bus.mdu_we_i, bus.alu_we_i};

  // Round-robin pointer: names the source that currently has highest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pri_q <= PRI_ALU;
    else        pri_q <= pri_d;
  end

  // Grant selection and pointer advance; reset and flush suppress every grant.
  always_comb begin
    grant_c = '0;
    pri_d   = pri_q;
    if (rst_n && !flush_i) begin
      case (pri_q)
        PRI_ALU: begin
          if      (req_c[0]) grant_c = 3'b001;
          else if (req_c[1]) grant_c = 3'b010;
          else if (req_c[2]) grant_c = 3'b100;
        end
        PRI_MDU: begin
          if      (req_c[1]) grant_c = 3'b010;
          else if (req_c[2]) grant_c = 3'b100;
          else if (req_c[0]) grant_c = 3'b001;
        end
        PRI_LSU: begin
          if      (req_c[2]) grant_c = 3'b100;
          else if (req_c[0]) grant_c = 3'b001;
          else if (req_c[1]) grant_c = 3'b010;
        end
        default: pri_d = PRI_ALU;
      endcase
    end
    if      (grant_c[0]) pri_d = PRI_MDU;
    else if (grant_c[1]) pri_d = PRI_LSU;
    else if (grant_c[2]) pri_d = PRI_ALU;
  end

  assign accept_c        = |grant_c;
  assign bus.alu_ready_o = grant_c[0];
  assign bus.mdu_ready_o = grant_c[1];
  assign bus.lsu_ready_o = grant_c[2];

  // Payload of the granted source; zero when nothing is granted.
  always_comb begin
    sel_waddr_c = '0;
    sel_wdata_c = '0;
    sel_id_c    = '0;
    if (grant_c[0]) begin
      sel_waddr_c = bus.alu_waddr_i;
      sel_wdata_c = bus.alu_wdata_i;
      sel_id_c    = bus.alu_commit_id_i;
    end else if (grant_c[1]) begin
      sel_waddr_c = bus.mdu_waddr_i;
      sel_wdata_c = bus.mdu_wdata_i;
      sel_id_c    = bus.mdu_commit_id_i;
    end else if (grant_c[2]) begin
      sel_waddr_c = bus.lsu_waddr_i;
      sel_wdata_c = bus.lsu_wdata_i;
      sel_id_c    = bus.lsu_commit_id_i;
    end
  end

  // One-entry output stage, reloaded every cycle; x0 writes retire without writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      retire_cnt_q   <= '0;
    end else begin
      rf_we_q        <= accept_c && (sel_waddr_c != '0);
      rf_waddr_q     <= sel_waddr_c;
      rf_wdata_q     <= sel_wdata_c;
      commit_valid_q <= accept_c;
      commit_id_q    <= sel_id_c;
      retire_cnt_q   <= retire_cnt_q + RETIRE_CNT_W'(accept_c);
    end
  end

  assign bus.rf_we_o        = rf_we_q;
  assign bus.rf_waddr_o     = rf_waddr_q;
  assign bus.rf_wdata_o     = rf_wdata_q;
  assign bus.commit_valid_o = commit_valid_q;
  assign bus.commit_id_o    = commit_id_q;
  assign bus.retire_cnt_o   = retire_cnt_q;

`ifdef WB_FWD_EN
  // Bypass the pending register-file write to operand fetch.
  assign bus.fwd_valid_o = rf_we_q;
  assign bus.fwd_waddr_o = rf_waddr_q;
  assign bus.fwd_wdata_o = rf_wdata_q;
`else
  assign bus.fwd_valid_o = 1'b0;
  assign bus.fwd_waddr_o = '0;
  assign bus.fwd_wdata_o = '0;
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter RETIRE_CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have, for each source s in {alu, mdu, lsu}: s_we_i  input  1  result valid with register write requested.
REQ-005 SHALL have, for each source s: s_waddr_i  input  `REG_ADDR_WIDTH  destination register.
REQ-006 SHALL have, for each source s: s_wdata_i  input  `REG_DATA_WIDTH  result data.
REQ-007 SHALL have, for each source s: s_commit_id_i  input  `COMMIT_ID_WIDTH  instruction ID.
REQ-008 SHALL have, for each source s: s_ready_o  output  1  result accepted this cycle.
REQ-009 SHALL have flush_i  input  1  pipeline flush on interrupt assertion.
REQ-010 SHALL have rf_we_o / rf_waddr_o / rf_wdata_o  output  1 / `REG_ADDR_WIDTH / `REG_DATA_WIDTH  register-file write port.
REQ-011 SHALL have commit_valid_o / commit_id_o  output  1 / `COMMIT_ID_WIDTH  retirement notification.
REQ-012 SHALL have fwd_valid_o / fwd_waddr_o / fwd_wdata_o  output  1 / `REG_ADDR_WIDTH / `REG_DATA_WIDTH  forwarding of the pending write.
REQ-013 SHALL have retire_cnt_o  output  RETIRE_CNT_W  count of retired instructions.

Function
REQ-014 SHALL grant at most one requesting source per cycle, round-robin order ALU->MDU->LSU, starting after the last-granted source.
REQ-015 SHALL assert s_ready_o combinationally only for the granted source; a transfer completes when s_we_i && s_ready_o.
REQ-016 SHALL not depend on s_ready_o to derive any s_we_i (no combinational loop); sources hold all inputs stable until accepted.
REQ-017 SHALL register the accepted transfer into a one-entry output stage: latency exactly 1 cycle from acceptance to rf_we_o/commit_valid_o.
REQ-018 SHALL present each output-stage entry for exactly one cycle (register file always accepts), so full throughput is one write per cycle.
REQ-019 SHALL drive commit_valid_o=1 for every accepted transfer, and rf_we_o=1 only if the registered waddr != 0; x0 writes retire without writing.
REQ-020 SHALL advance the round-robin pointer only on a completed transfer; with a single requester it is granted every cycle.
REQ-021 SHALL, under continuous requests from all three sources, serve each source once in every 3 consecutive cycles (no starvation).
REQ-022 SHALL, while flush_i=1, deassert all s_ready_o and load an empty output stage next cycle; flush has priority over any grant.
REQ-023 SHALL increment retire_cnt_o by 1 on each cycle with commit_valid_o=1, wrapping from all-ones to 0.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear rf_we_o, rf_waddr_o, rf_wdata_o, commit_valid_o, commit_id_o, fwd_* and retire_cnt_o to 0 and set the round-robin pointer so ALU has highest priority.
REQ-025 SHALL discard any in-flight output-stage entry if reset asserts mid-operation; no s_ready_o asserted while rst_n low.

Configuration
REQ-026 SHALL, with WB_FWD_EN defined, drive fwd_valid_o=rf_we_o, fwd_waddr_o=rf_waddr_o, fwd_wdata_o=rf_wdata_o for operand bypass.
REQ-027 SHALL, without WB_FWD_EN, tie fwd_valid_o, fwd_waddr_o, fwd_wdata_o to 0; all other behaviour identical.

Verification
REQ-028 SHALL cover: ALU alone, waddr=5, wdata=0x1234_5678, id=3 -> alu_ready_o same cycle; next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234_5678, commit_id_o=3.
REQ-029 SHALL cover: all three requesting continuously after reset for 6 cycles -> grant order ALU,MDU,LSU,ALU,MDU,LSU; retire_cnt_o=6 one cycle after the last grant.
REQ-030 SHALL cover: LSU write to x0, id=7 -> next cycle commit_valid_o=1, commit_id_o=7, rf_we_o=0.
REQ-031 SHALL cover: flush_i=1 with ALU and MDU requesting -> no ready asserted; next cycle commit_valid_o=0, rf_we_o=0, retire_cnt_o unchanged.
REQ-032 SHALL cover: retire_cnt_o preloaded to all-ones via RETIRE_CNT_W=4 and 16 retirements -> returns to 0; rst_n low mid-burst -> all outputs 0 immediately, ALU granted first after release.
REQ-033 SHALL cover: WB_FWD_EN defined vs undefined with ALU write waddr=9 -> fwd_valid_o=1, fwd_waddr_o=9 vs fwd_* constantly 0.
